// File: rtl/shift_store_window_ctrl_if.sv
// Stream and window handshake between the window controller, its producer,
// the shift-register store and the window consumer.
interface shift_store_window_ctrl_if #(
    parameter int Bits = 8
);
    logic            in_valid_i;
    logic            in_ready_o;
    logic [Bits-1:0] in_data_i;
    logic            sreg_en_o;
    logic [Bits-1:0] sreg_data_o;
    logic            win_valid_o;
    logic            win_ack_i;

    modport slave (
        input  in_valid_i, in_data_i, win_ack_i,
        output in_ready_o, sreg_en_o, sreg_data_o, win_valid_o
    );

    modport master (
        output in_valid_i, in_data_i, win_ack_i,
        input  in_ready_o, sreg_en_o, sreg_data_o, win_valid_o
    );
endinterface

// File: rtl/shift_store_window_ctrl.sv
// Sliding-window controller: fills a Length-deep shift store, presents a window,
// then shifts in Stride words per window until the frame is used up.
module shift_store_window_ctrl #(
    parameter int Bits   = 8,
    parameter int Length = 4,
    parameter int Stride = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       abort_i,
    input  logic [15:0]                frame_len_i,
    shift_store_window_ctrl_if.slave   bus,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [15:0]                win_count_o
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WINDOW,
        SLIDE,
        DRAIN,
        DONE
    } state_e;

    localparam logic [15:0] LenW    = 16'(Length);
    localparam logic [15:0] StrideW = 16'(Stride);

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [15:0] consumed_q, consumed_d;
    logic [15:0] fill_q, fill_d;
    logic [15:0] slide_q, slide_d;
    logic [15:0] win_count_q, win_count_d;
    logic [15:0] rem;
    logic        acc;
    logic [Bits-1:0] data_w;

    // DRAIN stops offering ready once the frame is used up, so len = 0 takes no word
    assign bus.in_ready_o  = (state_q == FILL) || (state_q == SLIDE) ||
                             ((state_q == DRAIN) && (consumed_q != len_q));
    assign acc             = bus.in_valid_i & bus.in_ready_o;
    assign bus.sreg_en_o   = acc & ((state_q == FILL) || (state_q == SLIDE)) & ~abort_i;
    assign data_w          = bus.in_data_i;
    assign bus.sreg_data_o = data_w;
    assign bus.win_valid_o = (state_q == WINDOW);
    assign busy_o          = (state_q != IDLE);
    assign done_o          = (state_q == DONE);
    assign win_count_o     = win_count_q;
    assign rem             = len_q - consumed_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        consumed_d  = consumed_q;
        fill_d      = fill_q;
        slide_d     = slide_q;
        win_count_d = win_count_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d       = frame_len_i;
                    consumed_d  = '0;
                    fill_d      = '0;
                    slide_d     = '0;
                    win_count_d = '0;
                    state_d     = (frame_len_i >= LenW) ? FILL : DRAIN;
                end
            end
            FILL: begin
                if (acc) begin
                    fill_d     = fill_q + 16'd1;
                    consumed_d = consumed_q + 16'd1;
                    if (fill_q + 16'd1 == LenW) state_d = WINDOW;
                end
            end
            WINDOW: begin
                if (bus.win_ack_i) begin
                    win_count_d = win_count_q + 16'd1;
                    if (rem == 16'd0) begin
                        state_d = DONE;
                    end else if (rem < StrideW) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = SLIDE;
                        slide_d = '0;
                    end
                end
            end
            SLIDE: begin
                if (acc) begin
                    slide_d    = slide_q + 16'd1;
                    consumed_d = consumed_q + 16'd1;
                    if (slide_q + 16'd1 == StrideW) state_d = WINDOW;
                end
            end
            DRAIN: begin
                if (consumed_q == len_q) begin
                    state_d = DONE;
                end else if (acc) begin
                    consumed_d = consumed_q + 16'd1;
                    if (consumed_q + 16'd1 == len_q) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over any accept or ack in the same cycle and leaves counters untouched
        if (abort_i) begin
            state_d     = IDLE;
            len_d       = len_q;
            consumed_d  = consumed_q;
            fill_d      = fill_q;
            slide_d     = slide_q;
            win_count_d = win_count_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            len_q       <= '0;
            consumed_q  <= '0;
            fill_q      <= '0;
            slide_q     <= '0;
            win_count_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            consumed_q  <= consumed_d;
            fill_q      <= fill_d;
            slide_q     <= slide_d;
            win_count_q <= win_count_d;
        end
    end

endmodule

// File: tb/tb_shift_store_window_ctrl.sv
// Directed bench for shift_store_window_ctrl with Length=4, Stride=2, Bits=8:
// per-cycle vector table plus hand-written multi-cycle sequences.
module tb_shift_store_window_ctrl;

    typedef struct {
        logic        start;
        logic        abort;
        logic [15:0] len;
        logic        valid;
        logic [7:0]  data;
        logic        ack;
        logic        eReady;
        logic        eEn;
        logic        eWv;
        logic        eBusy;
        logic        eDone;
        logic [15:0] eWc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] frameLen;
    logic        busy;
    logic        done;
    logic [15:0] winCount;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[$];

    shift_store_window_ctrl_if #(.Bits(8)) bus ();

    shift_store_window_ctrl #(.Bits(8), .Length(4), .Stride(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .abort_i     (abort),
        .frame_len_i (frameLen),
        .bus         (bus),
        .busy_o      (busy),
        .done_o      (done),
        .win_count_o (winCount)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic addV(input logic st, input logic ab, input logic [15:0] len, input logic va,
                        input logic [7:0] d, input logic ack, input logic rdy, input logic en,
                        input logic wv, input logic bs, input logic dn, input logic [15:0] wc);
        vec_t v;
        v.start = st; v.abort = ab; v.len = len; v.valid = va; v.data = d; v.ack = ack;
        v.eReady = rdy; v.eEn = en; v.eWv = wv; v.eBusy = bs; v.eDone = dn; v.eWc = wc;
        vecs.push_back(v);
    endtask

    // Words 1..8 with an immediate ack on the first two windows
    task automatic addStream8();
        for (int k = 1; k <= 4; k++) addV(0, 0, 0, 1, 8'(k), 0, 1, 1, 0, 1, 0, 0);
        addV(0, 0, 0, 1, 5, 1, 0, 0, 1, 1, 0, 0);
        addV(0, 0, 0, 1, 5, 0, 1, 1, 0, 1, 0, 1);
        addV(0, 0, 0, 1, 6, 0, 1, 1, 0, 1, 0, 1);
        addV(0, 0, 0, 1, 7, 1, 0, 0, 1, 1, 0, 1);
        addV(0, 0, 0, 1, 7, 0, 1, 1, 0, 1, 0, 2);
        addV(0, 0, 0, 1, 8, 0, 1, 1, 0, 1, 0, 2);
    endtask

    task automatic applyStimulus(input vec_t v);
        start          = v.start;
        abort          = v.abort;
        frameLen       = v.len;
        bus.in_valid_i = v.valid;
        bus.in_data_i  = v.data;
        bus.win_ack_i  = v.ack;
    endtask

    task automatic clearInputs();
        start = 0; abort = 0; frameLen = 0;
        bus.in_valid_i = 0; bus.in_data_i = 0; bus.win_ack_i = 0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, ".ready"}, 16'(bus.in_ready_o), 0);
        checkOutput({tag, ".en"}, 16'(bus.sreg_en_o), 0);
        checkOutput({tag, ".wv"}, 16'(bus.win_valid_o), 0);
        checkOutput({tag, ".busy"}, 16'(busy), 0);
        checkOutput({tag, ".done"}, 16'(done), 0);
        checkOutput({tag, ".wc"}, winCount, 0);
    endtask

    task automatic runTable();
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.ready", i), 16'(bus.in_ready_o), 16'(vecs[i].eReady));
            checkOutput($sformatf("v%0d.en", i), 16'(bus.sreg_en_o), 16'(vecs[i].eEn));
            checkOutput($sformatf("v%0d.data", i), 16'(bus.sreg_data_o), 16'(vecs[i].data));
            checkOutput($sformatf("v%0d.wv", i), 16'(bus.win_valid_o), 16'(vecs[i].eWv));
            checkOutput($sformatf("v%0d.busy", i), 16'(busy), 16'(vecs[i].eBusy));
            checkOutput($sformatf("v%0d.done", i), 16'(done), 16'(vecs[i].eDone));
            checkOutput($sformatf("v%0d.wc", i), winCount, vecs[i].eWc);
        end
    endtask

    // len=8, valid toggling every cycle, each window acked on its sixth cycle
    task automatic runToggleSequence();
        logic [7:0] pushed[$];
        int w = 1, winCycles = 0, windows = 0, doneSeen = 0;
        bit toggle = 1'b1, finished = 1'b0;
        @(posedge clk); #1;
        clearInputs();
        start = 1; frameLen = 16'd8;
        for (int c = 0; c < 200 && !finished; c++) begin
            @(posedge clk); #1;
            start = 0;
            bus.in_valid_i = toggle;
            toggle = ~toggle;
            bus.in_data_i = 8'(w);
            bus.win_ack_i = bus.win_valid_o && (winCycles >= 5);
            #1;
            if (bus.win_valid_o) begin
                checkOutput("tog.winReady", 16'(bus.in_ready_o), 0);
                checkOutput("tog.winEn", 16'(bus.sreg_en_o), 0);
                if (winCycles == 0) checkOutput("tog.winWords", 16'(pushed.size()), 16'(4 + 2 * windows));
                winCycles++;
                if (bus.win_ack_i) begin
                    windows++;
                    winCycles = 0;
                end
            end
            if (bus.sreg_en_o) pushed.push_back(bus.sreg_data_o);
            if (bus.in_valid_i && bus.in_ready_o) w++;
            if (done) begin
                doneSeen++;
                finished = 1'b1;
            end
        end
        checkOutput("tog.finished", 16'(finished), 1);
        checkOutput("tog.windows", 16'(windows), 3);
        checkOutput("tog.pushCount", 16'(pushed.size()), 8);
        for (int k = 0; k < pushed.size() && k < 8; k++)
            checkOutput($sformatf("tog.word%0d", k), 16'(pushed[k]), 16'(k + 1));
        checkOutput("tog.wc", winCount, 3);
        @(posedge clk); #1;
        bus.in_valid_i = 0;
        #1;
        checkOutput("tog.doneOnce", 16'(done), 0);
        checkOutput("tog.idle", 16'(busy), 0);
    endtask

    task automatic runResetSequence();
        int w = 1, windows = 0, enCount = 0, doneSeen = 0;
        bit finished = 1'b0;
        @(posedge clk); #1;
        clearInputs();
        start = 1; frameLen = 16'd8;
        @(posedge clk); #1;
        start = 0; bus.in_valid_i = 1; bus.in_data_i = 8'd1;
        @(posedge clk); #1;
        bus.in_data_i = 8'd2;
        @(posedge clk); #1;
        bus.in_data_i = 8'd3;
        #1;
        checkOutput("rstFill.busyBefore", 16'(busy), 1);
        rst = 1;
        #1;
        checkIdleOutputs("rstFill");
        @(posedge clk); #3;
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.in_valid_i = 1;
            #1;
            checkOutput("rstFill.noRestartBusy", 16'(busy), 0);
            checkOutput("rstFill.noRestartReady", 16'(bus.in_ready_o), 0);
        end
        @(posedge clk); #1;
        bus.in_valid_i = 0; start = 1; frameLen = 16'd4;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(posedge clk); #1;
            start = 0;
            bus.in_valid_i = 1;
            bus.in_data_i = 8'(w);
            bus.win_ack_i = bus.win_valid_o;
            #1;
            if (bus.sreg_en_o) enCount++;
            if (bus.win_valid_o && bus.win_ack_i) windows++;
            if (bus.in_valid_i && bus.in_ready_o) w++;
            if (done) begin
                doneSeen++;
                finished = 1'b1;
            end
        end
        checkOutput("len4.finished", 16'(finished), 1);
        checkOutput("len4.windows", 16'(windows), 1);
        checkOutput("len4.enCount", 16'(enCount), 4);
        checkOutput("len4.wc", winCount, 1);
        checkOutput("len4.doneSeen", 16'(doneSeen), 1);
    endtask

    initial begin
        clearInputs();
        rst = 1;
        @(posedge clk);
        @(posedge clk); #1;
        checkIdleOutputs("inReset");
        rst = 0;

        // len=8 continuous stream, immediate ack
        addV(1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addStream8();
        addV(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 2);
        addV(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
        addV(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        // len=9: ninth word drained without a shift
        addV(1, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        addStream8();
        addV(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 2);
        addV(0, 0, 0, 1, 9, 0, 1, 0, 0, 1, 0, 3);
        addV(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3);
        addV(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        // len=3: shorter than the window, all drained
        addV(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 3);
        for (int k = 1; k <= 3; k++) addV(0, 0, 0, 1, 8'(k), 0, 1, 0, 0, 1, 0, 0);
        addV(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        addV(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // len=0: done two cycles after start, nothing accepted
        addV(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addV(0, 0, 0, 1, 8'hAA, 0, 0, 0, 0, 1, 0, 0);
        addV(0, 0, 0, 1, 8'hAA, 0, 0, 0, 0, 1, 1, 0);
        addV(0, 0, 0, 1, 8'hAA, 0, 0, 0, 0, 0, 0, 0);
        // start ignored during FILL, then abort in SLIDE with a word offered
        addV(1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addV(1, 0, 2, 1, 1, 0, 1, 1, 0, 1, 0, 0);
        addV(1, 0, 2, 1, 2, 0, 1, 1, 0, 1, 0, 0);
        addV(0, 0, 0, 1, 3, 0, 1, 1, 0, 1, 0, 0);
        addV(0, 0, 0, 1, 4, 0, 1, 1, 0, 1, 0, 0);
        addV(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        addV(0, 1, 0, 1, 5, 0, 1, 0, 0, 1, 0, 1);
        addV(0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1);
        addV(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        runTable();

        // Reset while idle must clear the window count left by the aborted frame
        @(posedge clk); #1;
        clearInputs();
        #1;
        checkOutput("idleRst.wcBefore", winCount, 1);
        rst = 1;
        #1;
        checkOutput("idleRst.wc", winCount, 0);
        @(posedge clk); #3;
        rst = 0;

        runToggleSequence();
        runResetSequence();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_store_window_ctrl.md
SHIFT_STORE_WINDOW_CTRL -- requirements
Module: shift_store_window_ctrl

Interface
REQ-001 SHALL have parameter Bits, default 8: word width forwarded to the shift-register store.
REQ-002 SHALL have parameter Length, default 4: store depth (window size), legal range 1..65535.
REQ-003 SHALL have parameter Stride, default 1: words shifted between consecutive windows, legal range 1..Length.
REQ-004 SHALL have port clk_i  input  1  clock; reset rst_i, asynchronous, active-high.
REQ-005 SHALL have port rst_i  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start_i  input  1  begin frame; sampled only in IDLE.
REQ-007 SHALL have port abort_i  input  1  synchronous abort, back to IDLE.
REQ-008 SHALL have port frame_len_i  input  16  words in frame; latched on accepted start.
REQ-009 SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1) and in_data_i (input, Bits): input stream handshake.
REQ-010 SHALL have ports sreg_en_o (output, 1) and sreg_data_o (output, Bits): shift enable and data driven to the store.
REQ-011 SHALL have ports win_valid_o (output, 1) and win_ack_i (input, 1): store holds a complete window; consumer acknowledge.
REQ-012 SHALL have ports busy_o (output, 1), done_o (output, 1, one-cycle pulse) and win_count_o (output, 16, windows acknowledged this frame).

Function
REQ-013 SHALL implement states IDLE, FILL, WINDOW, SLIDE, DRAIN, DONE.
REQ-014 Handshake SHALL be acc = in_valid_i & in_ready_o; in_ready_o SHALL be 1 only in FILL, SLIDE and DRAIN.
REQ-015 sreg_data_o SHALL equal in_data_i combinationally; sreg_en_o SHALL equal acc in FILL/SLIDE and 0 in every other state.
REQ-016 IDLE with start_i=1: latch frame_len_i, clear consumed, fill, slide and win_count counters; if frame_len_i >= Length, go to FILL, else go to DRAIN.
REQ-017 FILL: each acc increments fill and consumed counters; the acc bringing fill to Length SHALL move to WINDOW next cycle.
REQ-018 WINDOW: win_valid_o=1, no input accepted; on win_ack_i, win_count increments, then rem = len - consumed selects the next state.
REQ-019 From WINDOW on ack: rem = 0 goes to DONE; 0 < rem < Stride goes to DRAIN; rem >= Stride goes to SLIDE with slide counter cleared.
REQ-020 SLIDE: each acc increments slide and consumed counters; the acc bringing slide to Stride SHALL move to WINDOW.
REQ-021 DRAIN: accepts and discards words (sreg_en_o=0) until consumed = len, then goes to DONE; len = 0 SHALL go directly to DONE.
REQ-022 DONE: done_o=1 for exactly one cycle, then IDLE.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 start_i outside IDLE SHALL be ignored.
REQ-025 abort_i=1 in any state SHALL force IDLE next cycle with no done_o pulse; win_count_o keeps its value; abort SHALL take priority over simultaneous acc or ack.
REQ-026 win_ack_i outside WINDOW SHALL be ignored.
REQ-027 All counters SHALL be 16-bit; consumed never exceeds len, so no wrap-around occurs.

Reset
REQ-028 rst_i=1 SHALL immediately force IDLE and clear all counters.
REQ-029 During rst_i=1, in_ready_o, sreg_en_o, win_valid_o, busy_o, done_o SHALL be 0 and win_count_o SHALL be 0.
REQ-030 Reset mid-frame SHALL discard the frame; a new start_i SHALL be required after reset release.

Verification (Length=4, Stride=2, Bits=8)
REQ-031 Bench SHALL cover: len=8, data 1..8 streamed continuously, immediate ack -> windows after words 4, 6, 8; sreg_en_o high for 8 cycles; done_o once; win_count_o=3.
REQ-032 Bench SHALL cover: len=9 -> 3 windows; word 9 accepted with sreg_en_o=0 (DRAIN); done_o; win_count_o=3.
REQ-033 Bench SHALL cover: len=3 -> 3 words accepted, sreg_en_o never high, win_valid_o never high; done_o; win_count_o=0. Also len=0 -> DONE two cycles after start, no input accepted.
REQ-034 Bench SHALL cover: len=8, in_valid_i toggling every cycle, ack delayed 5 cycles -> in_ready_o=0 and sreg_en_o=0 throughout WINDOW; same 3 windows with the same data order.
REQ-035 Bench SHALL cover: abort_i asserted in SLIDE together with acc -> IDLE next cycle, no sreg_en_o that cycle, no done_o; also start_i during FILL ignored.
REQ-036 Bench SHALL cover: rst_i asserted mid-FILL -> outputs 0 immediately; a subsequent start with len=4 yields exactly one window, then done_o.
